card_selector: RTL and testbench
================================

# card_selector

Player input stage of the memory game: conditions the raw Izq/Der/Sel pushbuttons, moves a card cursor over the 4×4 board and collects up to two card picks per turn. Sits directly upstream of the game FSM; drives its `cartas_seleccionadas` and `se_eligio_carta` inputs, and its cursor output feeds the video generator for highlighting. Reads the live card array to reject matched or duplicate picks.

## Interface
- `N_CARDS`, 16: board size; cursor and index width is `$clog2(N_CARDS)`.
- `CARD_W`, 5: bits per card-array entry.
- `DEB_CYCLES`, 500000: consecutive stable samples needed to accept a button level (10 ms at 50 MHz).

- `clk` in 1: system clock (50 MHz).
- `rst` in 1: asynchronous, active-low reset.
- `izq`, `der`, `sel` in 1 each: raw pushbuttons, active-high, asynchronous to `clk`.
- `enable` in 1: high while the FSM is in a card-selection state.
- `clear` in 1: one-cycle pulse from the FSM after a pair has been evaluated.
- `arr_cartas` in `[CARD_W-1:0] [0:N_CARDS-1]`: current board; bit `CARD_W-1` = matched flag.
- `cursor` out 4: board position under the cursor.
- `cartas_sw` out 2: number of cards picked this turn (0, 1, 2).
- `se_eligio_carta` out 1: one-cycle pulse per accepted pick.
- `first_idx`, `second_idx` out 4 each: indices of the accepted picks.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after `DEB_CYCLES` consecutive equal samples.
  - A rising edge of the debounced level yields a one-cycle press pulse.
- Cursor: the `der` pulse increments and wraps 15→0; the `izq` pulse decrements and wraps 0→15.
  - The cursor moves only while `enable` = 1.
  - If `izq` and `der` pulse in the same cycle, the cursor does not move.
- The pick state machine has three states:
  - IDLE (`cartas_sw` = 0) → ONE on an accepted `sel`; latch `first_idx` = cursor.
  - ONE (`cartas_sw` = 1) → TWO on an accepted `sel`; latch `second_idx` = cursor.
  - TWO (`cartas_sw` = 2): all `sel` pulses are ignored; hold until `clear`.
  - `clear` in any state → IDLE. Indices and cursor are retained.
- A `sel` pulse is accepted only if all of the following hold; otherwise it is silently dropped:
  - `enable` = 1;
  - the state is not TWO;
  - `arr_cartas[cursor]` matched bit = 0;
  - in ONE, cursor ≠ `first_idx`.
- On each accepted pick, `se_eligio_carta` pulses in the same cycle the state advances.
- `clear` and `sel` in the same cycle: `clear` wins, and the `sel` is dropped, not deferred.
- `enable` falling in ONE keeps the state; picking resumes when `enable` returns.

## Timing
- Reset values: `cursor` = 0, `cartas_sw` = 0, `se_eligio_carta` = 0, `first_idx` = `second_idx` = 0. Debouncers reset to the released level with counters at 0.
- Latency from a clean raw press to the press pulse is 2 (sync) + `DEB_CYCLES` + 1 (edge) cycles. The cursor, state and outputs update on the next edge (+1).
- All outputs are registered; none is combinational from the inputs.
- `arr_cartas` is sampled in the cycle the `sel` pulse is evaluated.
- Reset mid-debounce discards the pending press.
- A press held longer than `DEB_CYCLES` produces exactly one pulse, with no auto-repeat.

## Configuration
- `CURSOR_SKIP_MATCHED_EN` defined: `izq`/`der` move the cursor to the nearest unmatched card in that direction, with wrap-around, searching at most `N_CARDS-1` positions. If none exists, the cursor stays put.
  - If the card under the cursor becomes matched, the cursor does not move until the next press.
- Undefined: every move is exactly ±1 with wrap; matched cards are only rejected at `sel`.

## Structure
- Shared package `memory_pkg` holds:
  - `N_CARDS`, `CARD_W` and `MATCHED_BIT` = `CARD_W-1`;
  - the enum `sel_state_t {SEL_IDLE, SEL_ONE, SEL_TWO}`;
  - the card-array typedef shared with the card controller and video generator.
- One sub-module, `button_conditioner` (synchronizer + debounce counter + rising-edge pulse, parameter `DEB_CYCLES`), instantiated three times.

## Test plan
- `DEB_CYCLES` = 4, reset released, `enable` = 1. Three clean `der` presses → `cursor` = 3. Then one `izq` press → `cursor` = 2.
- At `cursor` = 0, an `izq` press → `cursor` = 15. At `cursor` = 15, a `der` press → `cursor` = 0.
- Bounce: `sel` toggles every 2 cycles for 20 cycles, then holds high for 10 cycles → exactly one `se_eligio_carta` pulse.
- Pick at 5, then `sel` again at 5 → dropped, `cartas_sw` stays 1. Move to 9 and pick → `cartas_sw` = 2, `first_idx` = 5, `second_idx` = 9. Pick at 10 → ignored. `clear` → `cartas_sw` = 0.
- `arr_cartas[3]` matched bit = 1, cursor at 3, `sel` → no pulse, `cartas_sw` unchanged. With `CURSOR_SKIP_MATCHED_EN`, cards 3–4 matched: `der` from 2 → `cursor` = 5.
- `clear` and a `sel` pulse in the same cycle while in ONE → `cartas_sw` = 0, no pulse. Assert `rst` low mid-turn → all outputs 0 asynchronously.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared memory-game types: board geometry, card-array typedef and pick-state enum.
// Also hosts the nearest-unmatched search used when CURSOR_SKIP_MATCHED_EN is defined.
package memory_pkg;

  localparam int unsigned N_CARDS     = 16;
  localparam int unsigned CARD_W      = 5;
  localparam int unsigned MATCHED_BIT = CARD_W - 1;
  localparam int unsigned IDX_W       = $clog2(N_CARDS);

  typedef logic [IDX_W-1:0]                  idx_t;
  typedef logic [CARD_W-1:0]                 card_t;
  typedef logic [0:N_CARDS-1][CARD_W-1:0]    card_arr_t;

  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_ONE  = 2'd1,
    SEL_TWO  = 2'd2
  } sel_state_t;

  // Walks at most N_CARDS-1 positions away from cur; returns cur if every other card is matched.
  function automatic idx_t next_unmatched(idx_t cur, logic fwd, card_arr_t arr);
    idx_t res;
    idx_t p;
    logic found;
    res   = cur;
    found = 1'b0;
    for (int unsigned k = 1; k < N_CARDS; k++) begin
      p = fwd ? idx_t'((32'(cur) + k) % N_CARDS)
              : idx_t'((32'(cur) + N_CARDS - k) % N_CARDS);
      if (!found && !arr[p][MATCHED_BIT]) begin
        res   = p;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/card_selector_if.sv
// Link between the card selector and the game FSM / video generator.
interface card_selector_if;
  import memory_pkg::*;

  logic      enable;
  logic      clear;
  card_arr_t arr_cartas;
  idx_t      cursor;
  logic [1:0] cartas_sw;
  logic      se_eligio_carta;
  idx_t      first_idx;
  idx_t      second_idx;

  modport slave (
    input  enable, clear, arr_cartas,
    output cursor, cartas_sw, se_eligio_carta, first_idx, second_idx
  );

  modport master (
    output enable, clear, arr_cartas,
    input  cursor, cartas_sw, se_eligio_carta, first_idx, second_idx
  );
endinterface

// File: rtl/button_conditioner.sv
// Pushbutton front end: 2-flop synchronizer, consecutive-sample debouncer and a
// one-cycle pulse on each rising edge of the debounced level.
module button_conditioner #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_dly_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      // Any sample agreeing with the current level restarts the stability run.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/card_selector.sv
// Player input stage: conditions Izq/Der/Sel, moves the board cursor and collects two picks.
// Optional CURSOR_SKIP_MATCHED_EN makes Izq/Der jump to the nearest unmatched card.
module card_selector
  import memory_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  izq,
  input  logic                  der,
  input  logic                  sel,
  card_selector_if.slave        bus
);

  logic izq_p, der_p, sel_p;

  button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_izq (
    .clk(clk), .rst(rst), .btn(izq), .press(izq_p)
  );
  button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_der (
    .clk(clk), .rst(rst), .btn(der), .press(der_p)
  );
  button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_sel (
    .clk(clk), .rst(rst), .btn(sel), .press(sel_p)
  );

  idx_t       cursor_q, cursor_d;
  idx_t       first_q, second_q;
  sel_state_t state_q;
  logic [1:0] sw_q;
  logic       pulse_q;
  logic       pick_ok;

  always_comb begin
    cursor_d = cursor_q;
    if (bus.enable && (izq_p ^ der_p)) begin
`ifdef CURSOR_SKIP_MATCHED_EN
      cursor_d = next_unmatched(cursor_q, der_p, bus.arr_cartas);
`else
      if (der_p) begin
        cursor_d = (cursor_q == idx_t'(N_CARDS - 1)) ? '0 : cursor_q + 1'b1;
      end else begin
        cursor_d = (cursor_q == '0) ? idx_t'(N_CARDS - 1) : cursor_q - 1'b1;
      end
`endif
    end
  end

  always_comb begin
    pick_ok = sel_p && bus.enable && (state_q != SEL_TWO) &&
              !bus.arr_cartas[cursor_q][MATCHED_BIT] &&
              !((state_q == SEL_ONE) && (cursor_q == first_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cursor_q <= '0;
      state_q  <= SEL_IDLE;
      sw_q     <= 2'd0;
      pulse_q  <= 1'b0;
      first_q  <= '0;
      second_q <= '0;
    end else begin
      cursor_q <= cursor_d;
      pulse_q  <= 1'b0;
      // clear beats a coincident pick; that pick is lost, not queued.
      if (bus.clear) begin
        state_q <= SEL_IDLE;
        sw_q    <= 2'd0;
      end else if (pick_ok) begin
        pulse_q <= 1'b1;
        if (state_q == SEL_IDLE) begin
          state_q <= SEL_ONE;
          sw_q    <= 2'd1;
          first_q <= cursor_q;
        end else begin
          state_q  <= SEL_TWO;
          sw_q     <= 2'd2;
          second_q <= cursor_q;
        end
      end
    end
  end

  assign bus.cursor          = cursor_q;
  assign bus.cartas_sw       = sw_q;
  assign bus.se_eligio_carta = pulse_q;
  assign bus.first_idx       = first_q;
  assign bus.second_idx      = second_q;

endmodule

// File: tb/tb_card_selector.sv
// Directed bench for card_selector with a transaction-level model of cursor and picks.
module tb_card_selector;
  import memory_pkg::*;

  localparam int unsigned DEB  = 4;
  localparam int          HOLD = DEB + 8;

  logic clk = 1'b0;
  logic rst, izq, der, sel;
  card_arr_t board;

  card_selector_if bus ();

  card_selector #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .izq(izq), .der(der), .sel(sel), .bus(bus)
  );

  always #5 clk = ~clk;
  always_comb bus.arr_cartas = board;

  int n_total = 0;
  int n_pass  = 0;
  int dut_pulses = 0;
  bit chk_en = 1'b0;

  int m_cursor, m_sw, m_first, m_second, m_pulses;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) if (rst && bus.se_eligio_carta) dut_pulses++;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cursor", int'(bus.cursor), m_cursor);
      chk("cartas_sw", int'(bus.cartas_sw), m_sw);
      chk("first_idx", int'(bus.first_idx), m_first);
      chk("second_idx", int'(bus.second_idx), m_second);
      chk("quiet_pulse", int'(bus.se_eligio_carta), 0);
      chk("pulse_count", dut_pulses, m_pulses);
    end
  end

  task automatic m_reset();
    m_cursor = 0; m_sw = 0; m_first = 0; m_second = 0;
  endtask

  task automatic m_move(input int dir);
    if (!bus.enable) return;
`ifdef CURSOR_SKIP_MATCHED_EN
    for (int k = 1; k < int'(N_CARDS); k++) begin
      int p;
      p = (m_cursor + dir * k + 2 * int'(N_CARDS)) % int'(N_CARDS);
      if (!board[p][MATCHED_BIT]) begin
        m_cursor = p;
        return;
      end
    end
`else
    m_cursor = (m_cursor + dir + int'(N_CARDS)) % int'(N_CARDS);
`endif
  endtask

  task automatic m_pick();
    if (bus.enable && m_sw != 2 && !board[m_cursor][MATCHED_BIT] &&
        !(m_sw == 1 && m_cursor == m_first)) begin
      if (m_sw == 0) m_first = m_cursor;
      else m_second = m_cursor;
      m_sw++;
      m_pulses++;
    end
  endtask

  task automatic settle();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // which: 0 izq, 1 der, 2 sel, 3 izq+der together
  task automatic press(input int which);
    chk_en = 1'b0;
    izq = (which == 0 || which == 3);
    der = (which == 1 || which == 3);
    sel = (which == 2);
    repeat (HOLD) @(posedge clk);
    #1;
    izq = 1'b0; der = 1'b0; sel = 1'b0;
    repeat (HOLD) @(posedge clk);
    #1;
    if (which == 0) m_move(-1);
    else if (which == 1) m_move(1);
    else if (which == 2) m_pick();
    settle();
  endtask

  task automatic do_clear();
    chk_en = 1'b0;
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    m_sw = 0;
    settle();
  endtask

  initial begin
    int p0;
    rst = 1'b0; izq = 1'b0; der = 1'b0; sel = 1'b0;
    bus.enable = 1'b1; bus.clear = 1'b0; board = '0;
    m_reset();
    m_pulses = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cursor", int'(bus.cursor), 0);
    chk("reset_sw", int'(bus.cartas_sw), 0);
    chk("reset_pulse", int'(bus.se_eligio_carta), 0);
    chk("reset_first", int'(bus.first_idx), 0);
    chk("reset_second", int'(bus.second_idx), 0);
    rst = 1'b1;
    settle();

    repeat (3) press(1);
    chk("der_x3", int'(bus.cursor), 3);
    press(0);
    chk("izq_x1", int'(bus.cursor), 2);
    repeat (2) press(0);
    press(0);
    chk("wrap_0_to_15", int'(bus.cursor), 15);
    press(1);
    chk("wrap_15_to_0", int'(bus.cursor), 0);

    // Bouncing sel: never four equal samples until the final steady hold.
    chk_en = 1'b0;
    p0 = dut_pulses;
    for (int i = 0; i < 10; i++) begin
      sel = ~sel;
      repeat (2) @(posedge clk);
      #1;
    end
    sel = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    sel = 1'b0;
    repeat (HOLD) @(posedge clk);
    #1;
    chk("bounce_one_pulse", dut_pulses - p0, 1);
    m_pick();
    settle();
    do_clear();

    repeat (5) press(1);
    press(2);
    press(2);
    chk("dup_pick_dropped", int'(bus.cartas_sw), 1);
    repeat (4) press(1);
    press(2);
    chk("two_sw", int'(bus.cartas_sw), 2);
    chk("two_first", int'(bus.first_idx), 5);
    chk("two_second", int'(bus.second_idx), 9);
    press(1);
    press(2);
    chk("pick_in_two_ignored", int'(bus.cartas_sw), 2);
    do_clear();
    chk("clear_sw", int'(bus.cartas_sw), 0);

    repeat (7) press(0);
    board[3][MATCHED_BIT] = 1'b1;
    p0 = dut_pulses;
    press(2);
    chk("matched_no_pulse", dut_pulses - p0, 0);
    chk("matched_sw", int'(bus.cartas_sw), 0);
    chk("matched_cursor_stays", int'(bus.cursor), 3);

`ifdef CURSOR_SKIP_MATCHED_EN
    board[4][MATCHED_BIT] = 1'b1;
    press(0);
    press(1);
    chk("skip_matched_der", int'(bus.cursor), 5);
`else
    press(0);
    press(1);
    chk("plain_der_onto_matched", int'(bus.cursor), 3);
`endif
    for (int i = 0; i < int'(N_CARDS) && m_cursor != 5; i++) press(1);

    press(2);
    chk("pick_at_5", int'(bus.cartas_sw), 1);
    bus.enable = 1'b0;
    press(1);
    press(2);
    chk("disabled_hold_sw", int'(bus.cartas_sw), 1);
    bus.enable = 1'b1;
    press(3);
    chk("izq_der_same_cycle", int'(bus.cursor), 5);

    // sel pulse lands 3+DEB edges after the raw press; clear shares that cycle.
    chk_en = 1'b0;
    p0 = dut_pulses;
    press_clear_collide();
    chk("clear_wins_sw", int'(bus.cartas_sw), 0);
    chk("clear_wins_no_pulse", dut_pulses - p0, 0);

    press(2);
    press(1);
    press(2);
    chk("turn_before_reset", int'(bus.cartas_sw), 2);
    chk_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_cursor", int'(bus.cursor), 0);
    chk("async_rst_sw", int'(bus.cartas_sw), 0);
    chk("async_rst_pulse", int'(bus.se_eligio_carta), 0);
    chk("async_rst_first", int'(bus.first_idx), 0);
    chk("async_rst_second", int'(bus.second_idx), 0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    settle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  task automatic press_clear_collide();
    sel = 1'b1;
    repeat (3 + DEB) @(posedge clk);
    #1;
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    repeat (HOLD - 4 - DEB) @(posedge clk);
    #1;
    sel = 1'b0;
    repeat (HOLD) @(posedge clk);
    #1;
    m_sw = 0;
    settle();
  endtask

endmodule
